// File: rtl/sprite_layer_mixer.sv
// sprite_layer_mixer: priority sprite compositor over a background, two-stage pipeline, per-frame hit flags.
// Optional macro SPRITE_COLLISION_EN adds per-channel overlap-with-channel-0 flags on collide.
module sprite_layer_mixer #(
   parameter int NUM_SPR = 4,
   parameter int SPR_W = 28,
   parameter int SPR_H = 28,
   parameter logic [11:0] KEY_COLOR = 12'h000
) (
   input  logic                    clk_25m,
   input  logic                    rst_n,
   input  logic                    valid,
   input  logic [9:0]              hc,
   input  logic [9:0]              vc,
   input  logic                    frame_start,
   input  logic [NUM_SPR*10-1:0]   spr_x,
   input  logic [NUM_SPR*10-1:0]   spr_y,
   input  logic [NUM_SPR-1:0]      spr_en,
   output logic [NUM_SPR*17-1:0]   spr_addr,
   input  logic [NUM_SPR*12-1:0]   spr_data,
   input  logic [11:0]             bg_data,
   output logic [3:0]              vgaRed,
   output logic [3:0]              vgaGreen,
   output logic [3:0]              vgaBlue,
   output logic [NUM_SPR-1:0]      hit_mask,
   output logic [NUM_SPR-1:0]      collide
);
   logic [NUM_SPR*10-1:0] sh_x, sh_y;
   logic [NUM_SPR-1:0] sh_en, in0, in1, opq, acc;
   logic v1;
   logic [11:0] pix, rgb;
   always_ff @(posedge clk_25m or negedge rst_n)
      if (!rst_n) begin
         sh_x <= '0;
         sh_y <= '0;
         sh_en <= '0;
      end else if (frame_start) begin
         sh_x <= spr_x;
         sh_y <= spr_y;
         sh_en <= spr_en;
      end
   // 11-bit bounds so a sprite near 1023 never wraps back onto column/row 0
   for (genvar k = 0; k < NUM_SPR; k++) begin : g_ch
      logic [10:0] sx, sy, dx, dy;
      assign sx = {1'b0, sh_x[10*k +: 10]};
      assign sy = {1'b0, sh_y[10*k +: 10]};
      assign dx = {1'b0, hc} - sx;
      assign dy = {1'b0, vc} - sy;
      assign in0[k] = sh_en[k] && {1'b0, hc} >= sx && {1'b0, hc} < sx + 11'(SPR_W)
                      && {1'b0, vc} >= sy && {1'b0, vc} < sy + 11'(SPR_H);
      assign spr_addr[17*k +: 17] = in0[k] ? 17'(dx + SPR_W * dy) : '0;
      assign opq[k] = v1 && in1[k] && spr_data[12*k +: 12] != KEY_COLOR;
   end
   always_comb begin
      pix = bg_data;
      for (int i = NUM_SPR - 1; i >= 0; i--)
         if (opq[i]) pix = spr_data[12*i +: 12];
   end
   // opaque pixels seen on the frame_start cycle seed the new frame's accumulator
   always_ff @(posedge clk_25m or negedge rst_n)
      if (!rst_n) begin
         in1 <= '0;
         v1 <= 1'b0;
         rgb <= '0;
         acc <= '0;
         hit_mask <= '0;
      end else begin
         in1 <= in0;
         v1 <= valid;
         rgb <= v1 ? pix : '0;
         acc <= frame_start ? opq : acc | opq;
         if (frame_start) hit_mask <= acc;
      end
   assign vgaRed = rgb[11:8];
   assign vgaGreen = rgb[7:4];
   assign vgaBlue = rgb[3:0];
`ifdef SPRITE_COLLISION_EN
   logic [NUM_SPR-1:0] cacc, chit;
   assign chit = opq[0] ? (opq & ~NUM_SPR'(1)) : '0;
   always_ff @(posedge clk_25m or negedge rst_n)
      if (!rst_n) begin
         cacc <= '0;
         collide <= '0;
      end else begin
         cacc <= frame_start ? chit : cacc | chit;
         if (frame_start) collide <= cacc;
      end
`else
   assign collide = '0;
`endif
endmodule
